// File: rtl/psoc_audio_fifo.sv
// psoc_audio_fifo: show-ahead stereo sample FIFO between the CPU/bus and the DAC.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_data, wr_en    : 48-bit sample in ([23:0] left, [47:24] right), write strobe
//   full              : level == DEPTH
//   rd_en             : DAC read strobe
//   fifo_data         : head entry, 48'h0 (silence) while empty
//   empty, level      : level == 0, current fill level
//   irq               : registered refill request, (level <= IRQ_LEVEL) one cycle late
//   underrun          : sticky, set by a read while empty; cleared by clr_underrun
//   underrun_cnt      : saturating underrun event counter, present only when
//                       PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN is defined
module psoc_audio_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IRQ_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [47:0]                wr_data,
    input  logic                       wr_en,
    output logic                       full,
    input  logic                       rd_en,
    output logic [47:0]                fifo_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       irq,
    output logic                       underrun,
    input  logic                       clr_underrun
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned DW = 48;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          irq_q, irq_d;
    logic          underrun_q, underrun_d;
    logic          wr_ok, rd_ok, rd_empty;

    // Flags decode straight from the level register, never from the strobes.
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign irq       = irq_q;
    assign underrun  = underrun_q;
    assign fifo_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: when full, a write is still taken if a read frees a slot in the same cycle.
    always_comb begin
        wr_ok      = wr_en && (!full || rd_en);
        rd_ok      = rd_en && !empty;
        rd_empty   = rd_en && empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + LW'(wr_ok) - LW'(rd_ok);
        irq_d      = (level_q <= LW'(IRQ_LEVEL));
        underrun_d = underrun_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end else if (rd_empty) begin
            underrun_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            irq_q      <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            irq_q      <= irq_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating underrun counter; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_underrun) begin
            cnt_d = '0;
        end else if (rd_empty && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_psoc_audio_fifo.sv
// Directed self-checking bench for psoc_audio_fifo (DEPTH=16, IRQ_LEVEL=4).
module tb_psoc_audio_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        full;
    logic        rd_en;
    logic [47:0] fifo_data;
    logic        empty;
    logic [4:0]  level;
    logic        irq;
    logic        underrun;
    logic        clr_underrun;
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psoc_audio_fifo #(.DEPTH(16), .IRQ_LEVEL(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .rd_en        (rd_en),
        .fifo_data    (fifo_data),
        .empty        (empty),
        .level        (level),
        .irq          (irq),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] va(input int i);
        return 48'hA00000_000000 + 48'(i * 17 + 1);
    endfunction

    function automatic logic [47:0] vb(input int i);
        return 48'hB00000_500000 + 48'(i * 3 + 2);
    endfunction

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_underrun = 1'b0; wr_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_empty", 48'(empty), 48'd1);
        check("rst_full", 48'(full), 48'd0);
        check("rst_data", fifo_data, 48'h0);
        check("rst_irq", 48'(irq), 48'd1);
        check("rst_underrun", 48'(underrun), 48'd0);
        check("rst_level", 48'(level), 48'd0);

        // First write becomes the visible head one cycle later.
        wr_en = 1'b1; wr_data = 48'h123456_ABCDEF;
        tick();
        wr_en = 1'b0;
        check("w1_empty", 48'(empty), 48'd0);
        check("w1_level", 48'(level), 48'd1);
        check("w1_data", fifo_data, 48'h123456ABCDEF);
        check("w1_irq", 48'(irq), 48'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("r1_empty", 48'(empty), 48'd1);
        check("r1_data", fifo_data, 48'h0);

        // Fill to DEPTH, then an overflow write must be dropped.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = va(i);
            tick();
        end
        check("fill_full", 48'(full), 48'd1);
        check("fill_level", 48'(level), 48'd16);
        wr_data = 48'hFFFFFF_FFFFFF;
        tick();
        wr_en = 1'b0;
        check("ovf_full", 48'(full), 48'd1);
        check("ovf_level", 48'(level), 48'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_a%0d", i), fifo_data, va(i));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check("drain_empty", 48'(empty), 48'd1);
        check("drain_level", 48'(level), 48'd0);

        // Full FIFO with simultaneous read+write for 20 cycles.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = vb(i);
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            check($sformatf("rw_head%0d", j), fifo_data, vb(j));
            check($sformatf("rw_level%0d", j), 48'(level), 48'd16);
            wr_en = 1'b1; rd_en = 1'b1; wr_data = vb(16 + j);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_full", 48'(full), 48'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rw_drain%0d", i), fifo_data, vb(20 + i));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check("rw_empty", 48'(empty), 48'd1);

        // irq follows level with one cycle of lag.
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = va(40 + i);
            tick();
        end
        check("irq_l5_lvl", 48'(level), 48'd5);
        check("irq_l5", 48'(irq), 48'd1);
        wr_data = va(45);
        tick();
        wr_en = 1'b0;
        check("irq_l6", 48'(irq), 48'd0);
        tick();
        check("irq_l6_hold", 48'(irq), 48'd0);
        rd_en = 1'b1;
        tick();
        check("irq_r5", 48'(irq), 48'd0);
        tick();
        rd_en = 1'b0;
        check("irq_r4_lvl", 48'(level), 48'd4);
        check("irq_r4", 48'(irq), 48'd0);
        tick();
        check("irq_r4_next", 48'(irq), 48'd1);
        rd_en = 1'b1;
        tick(); tick(); tick(); tick();
        rd_en = 1'b0;
        check("irq_drain", 48'(empty), 48'd1);

        // Underrun: set, clear, clear-priority, re-set, write during underrun.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ur_set", 48'(underrun), 48'd1);
        check("ur_data", fifo_data, 48'h0);
        check("ur_level", 48'(level), 48'd0);
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        check("ur_cnt1", 48'(underrun_cnt), 48'd1);
`endif
        clr_underrun = 1'b1;
        tick();
        check("ur_clr", 48'(underrun), 48'd0);
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        check("ur_cnt_clr", 48'(underrun_cnt), 48'd0);
`endif
        rd_en = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("ur_clr_prio", 48'(underrun), 48'd0);
        wr_en = 1'b1; wr_data = 48'h0C0FFE_E00D00;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("ur_reset", 48'(underrun), 48'd1);
        check("ur_wr_level", 48'(level), 48'd1);
        check("ur_wr_data", fifo_data, 48'h0C0FFEE00D00);
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        check("ur_cnt_re", 48'(underrun_cnt), 48'd1);
`endif
        rd_en = 1'b1; clr_underrun = 1'b1;
        tick();
        rd_en = 1'b0; clr_underrun = 1'b0;
        check("ur_final", 48'(underrun), 48'd0);
        check("ur_final_empty", 48'(empty), 48'd1);

        // Reset mid-operation discards contents and ignores the write.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = va(60 + i);
            tick();
        end
        wr_en = 1'b0;
        check("mid_level8", 48'(level), 48'd8);
        rst_n = 1'b0; wr_en = 1'b1; wr_data = 48'h5A5A5A_5A5A5A;
        tick();
        rst_n = 1'b1; wr_en = 1'b0;
        check("mid_level", 48'(level), 48'd0);
        check("mid_empty", 48'(empty), 48'd1);
        check("mid_data", fifo_data, 48'h0);
        tick();
        check("mid_lost", 48'(level), 48'd0);
        check("mid_irq", 48'(irq), 48'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
